// File: rtl/gpio_signature_monitor.sv
// -----------------------------------------------------------------------------
// gpio_signature_monitor
//
// Checkpoint monitor for a GPIO signature bus (for example mprj_io[31:16]).
// Firmware steps the bus through an ordered list of signatures. Each signature
// must be held for STABLE consecutive cycles before the next one is awaited.
// A global cycle budget (TIMEOUT) bounds the run. In STRICT mode, a signature
// belonging to a later stage that is held stable ends the run with a failure.
//
// Ports
//   wb_clk_i   in   1             clock, rising edge
//   wb_rst_i   in   1             synchronous active-high reset
//   enable     in   1             level: 1 starts/keeps a run, 0 aborts/clears
//   sample     in   WIDTH         observed signature (used unregistered)
//   sig_table  in   STAGES*WIDTH  expected signatures, stage k at [k*WIDTH +: WIDTH]
//   busy       out  1             run in progress
//   stage_hit  out  1             one-cycle pulse when a stage is accepted
//   stage_idx  out  SW            index of the awaited stage (STAGES after pass)
//   pass       out  1             sticky success
//   fail       out  1             sticky failure
//   fail_code  out  2             01 timeout, 10 out-of-order, 00 otherwise
//   cycles     out  CNT_W         WAIT cycles elapsed, frozen once finished
// -----------------------------------------------------------------------------
module gpio_signature_monitor #(
  parameter int WIDTH   = 16,
  parameter int STAGES  = 2,
  parameter int STABLE  = 1,
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 32,
  parameter int STRICT  = 0,
  parameter int SW      = $clog2(STAGES + 1)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        sample,
  input  logic [STAGES*WIDTH-1:0] sig_table,
  output logic                    busy,
  output logic                    stage_hit,
  output logic [SW-1:0]           stage_idx,
  output logic                    pass,
  output logic                    fail,
  output logic [1:0]              fail_code,
  output logic [CNT_W-1:0]        cycles
);

  // Stability counters never need to hold STABLE itself: reaching STABLE-1 on
  // a matching cycle either accepts the stage or fails the run, and both clear
  // the counter.
  localparam int MCW = (STABLE > 1) ? $clog2(STABLE) : 1;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_OOO     = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PASS,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    stage_idx_q, stage_idx_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [MCW-1:0]   match_cnt_q, match_cnt_d;
  logic [MCW-1:0]   ooo_cnt_q, ooo_cnt_d;
  logic             hit_q, hit_d;
  logic [1:0]       fail_code_q, fail_code_d;

  // ---------------------------------------------------------------------------
  // Signature comparison
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] cur_sig;
  logic             later_hit;
  logic             match;
  logic             ooo;
  logic             accept;
  logic             ooo_fail;
  logic             tmo_hit;
  logic             last_stage;

  // The awaited signature is selected by comparison, not by a variable part
  // select, so that stage_idx == STAGES (after a pass) never indexes past the
  // table; outside WAIT the selection is unused.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cur_sig = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_idx_q == SW'(k)) begin
        cur_sig = sig_table[k*WIDTH +: WIDTH];
      end
    end
  end

  // A later stage matching the bus. Earlier stages (j < stage_idx) are
  // deliberately ignored: firmware may linger on an already-accepted value.
  always_comb begin
    later_hit = 1'b0;
    for (int j = 0; j < STAGES; j++) begin
      if ((SW'(j) > stage_idx_q) && (sample == sig_table[j*WIDTH +: WIDTH])) begin
        later_hit = 1'b1;
      end
    end
  end

  assign match      = (sample == cur_sig);
  assign ooo        = (STRICT != 0) && !match && later_hit;
  assign accept     = match && (match_cnt_q == MCW'(STABLE - 1));
  assign ooo_fail   = ooo && (ooo_cnt_q == MCW'(STABLE - 1));
  assign tmo_hit    = (cycles_q == CNT_W'(TIMEOUT - 1));
  assign last_stage = (stage_idx_q == SW'(STAGES - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    cycles_d    = cycles_q;
    match_cnt_d = match_cnt_q;
    ooo_cnt_d   = ooo_cnt_q;
    fail_code_d = fail_code_q;
    hit_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_WAIT;
          stage_idx_d = '0;
          cycles_d    = '0;
          match_cnt_d = '0;
          ooo_cnt_d   = '0;
          fail_code_d = CODE_NONE;
        end
      end

      S_WAIT: begin
        if (!enable) begin
          // Abort: back to IDLE with nothing reported.
          state_d     = S_IDLE;
          stage_idx_d = '0;
          cycles_d    = '0;
          match_cnt_d = '0;
          ooo_cnt_d   = '0;
          fail_code_d = CODE_NONE;
        end else begin
          cycles_d    = cycles_q + CNT_W'(1);
          match_cnt_d = match ? match_cnt_q + MCW'(1) : '0;
          ooo_cnt_d   = ooo ? ooo_cnt_q + MCW'(1) : '0;

          // Accept wins over out-of-order, which wins over timeout, so a
          // final stage accepted on the last budgeted cycle still passes.
          if (accept) begin
            hit_d       = 1'b1;
            stage_idx_d = stage_idx_q + SW'(1);
            match_cnt_d = '0;
            ooo_cnt_d   = '0;
            if (last_stage) begin
              state_d = S_PASS;
            end
          end else if (ooo_fail) begin
            state_d     = S_FAIL;
            fail_code_d = CODE_OOO;
          end else if (tmo_hit) begin
            state_d     = S_FAIL;
            fail_code_d = CODE_TIMEOUT;
          end
        end
      end

      S_PASS, S_FAIL: begin
        // Results are sticky until enable drops; enable held high does not
        // start a new run.
        if (!enable) begin
          state_d     = S_IDLE;
          stage_idx_d = '0;
          cycles_d    = '0;
          match_cnt_d = '0;
          ooo_cnt_d   = '0;
          fail_code_d = CODE_NONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      stage_idx_q <= '0;
      cycles_q    <= '0;
      match_cnt_q <= '0;
      ooo_cnt_q   <= '0;
      fail_code_q <= CODE_NONE;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_idx_q <= stage_idx_d;
      cycles_q    <= cycles_d;
      match_cnt_q <= match_cnt_d;
      ooo_cnt_q   <= ooo_cnt_d;
      fail_code_q <= fail_code_d;
      hit_q       <= hit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (state_q == S_WAIT);
  assign pass      = (state_q == S_PASS);
  assign fail      = (state_q == S_FAIL);
  assign stage_hit = hit_q;
  assign stage_idx = stage_idx_q;
  assign fail_code = fail_code_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_gpio_signature_monitor.sv
// -----------------------------------------------------------------------------
// Bench for gpio_signature_monitor. Two instances share the stimulus: one with
// STRICT=0 ("lax") and one with STRICT=1 ("strict"), both WIDTH=16, STAGES=2,
// STABLE=4, TIMEOUT=1000, sigs {AB60, AB61}.
//
// Event results (stage_hit pulses and fail rising) are scored by a monitor
// against queues filled by the stimulus; static snapshots (reset, abort,
// sticky state) are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_gpio_signature_monitor;

  localparam int WIDTH   = 16;
  localparam int STAGES  = 2;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1000;
  localparam int CNT_W   = 32;
  localparam int SW      = 2;

  localparam logic [15:0] SIG0 = 16'hAB60;
  localparam logic [15:0] SIG1 = 16'hAB61;

  typedef struct packed {
    logic        hit;
    logic [1:0]  idx;
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [31:0] cyc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic [WIDTH-1:0]        sample;
  logic [STAGES*WIDTH-1:0] sig_table;

  logic             l_busy, l_hit, l_pass, l_fail;
  logic [SW-1:0]    l_idx;
  logic [1:0]       l_code;
  logic [CNT_W-1:0] l_cycles;

  logic             s_busy, s_hit, s_pass, s_fail;
  logic [SW-1:0]    s_idx;
  logic [1:0]       s_code;
  logic [CNT_W-1:0] s_cycles;

  int vectors     = 0;
  int miscompares = 0;

  exp_t q_lax[$];
  exp_t q_str[$];

  always #5 clk = ~clk;

  gpio_signature_monitor #(
    .WIDTH(WIDTH), .STAGES(STAGES), .STABLE(STABLE), .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W), .STRICT(0), .SW(SW)
  ) dut_lax (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .enable   (enable),
    .sample   (sample),
    .sig_table(sig_table),
    .busy     (l_busy),
    .stage_hit(l_hit),
    .stage_idx(l_idx),
    .pass     (l_pass),
    .fail     (l_fail),
    .fail_code(l_code),
    .cycles   (l_cycles)
  );

  gpio_signature_monitor #(
    .WIDTH(WIDTH), .STAGES(STAGES), .STABLE(STABLE), .TIMEOUT(TIMEOUT),
    .CNT_W(CNT_W), .STRICT(1), .SW(SW)
  ) dut_strict (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .enable   (enable),
    .sample   (sample),
    .sig_table(sig_table),
    .busy     (s_busy),
    .stage_hit(s_hit),
    .stage_idx(s_idx),
    .pass     (s_pass),
    .fail     (s_fail),
    .fail_code(s_code),
    .cycles   (s_cycles)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic exp_t ev(input logic hit, input logic [1:0] idx,
                              input logic pass_v, input logic fail_v,
                              input logic [1:0] code, input logic [31:0] cyc);
    ev = '{hit: hit, idx: idx, pass: pass_v, fail: fail_v, code: code, cyc: cyc};
  endfunction

  // Snapshot layout: {busy, hit, idx, pass, fail, code, cycles}
  function automatic logic [39:0] mk(input logic b, input logic h,
                                     input logic [1:0] idx, input logic p,
                                     input logic f, input logic [1:0] code,
                                     input logic [31:0] cyc);
    mk = {b, h, idx, p, f, code, cyc};
  endfunction

  function automatic logic [39:0] snap_l();
    snap_l = {l_busy, l_hit, l_idx, l_pass, l_fail, l_code, l_cycles};
  endfunction

  function automatic logic [39:0] snap_s();
    snap_s = {s_busy, s_hit, s_idx, s_pass, s_fail, s_code, s_cycles};
  endfunction

  // Hold sample at s across n rising edges; returns 1 time unit after the last.
  task automatic step(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      sample = s;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input string tag);
    enable = 1'b1;
    step(16'h0000, 1);
    check({tag, "_start_lax"}, snap_l(), mk(1, 0, 0, 0, 0, 0, 0));
    check({tag, "_start_strict"}, snap_s(), mk(1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic end_run(input string tag);
    enable = 1'b0;
    step(16'h0000, 1);
    check({tag, "_clear_lax"}, snap_l(), 40'd0);
    check({tag, "_clear_strict"}, snap_s(), 40'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: scores every stage_hit pulse and every rising fail
  // ---------------------------------------------------------------------------
  logic l_fail_prev = 1'b0;
  logic s_fail_prev = 1'b0;

  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (rst) begin
      l_fail_prev = 1'b0;
      s_fail_prev = 1'b0;
    end else begin
      if (l_hit || (l_fail && !l_fail_prev)) begin
        got = {l_hit, l_idx, l_pass, l_fail, l_code, l_cycles};
        if (q_lax.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL lax_unexpected_event: got %h, expected none", got);
        end else begin
          want = q_lax.pop_front();
          check("lax_event", 64'(got), 64'(want));
        end
      end
      if (s_hit || (s_fail && !s_fail_prev)) begin
        got = {s_hit, s_idx, s_pass, s_fail, s_code, s_cycles};
        if (q_str.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL strict_unexpected_event: got %h, expected none", got);
        end else begin
          want = q_str.pop_front();
          check("strict_event", 64'(got), 64'(want));
        end
      end
      l_fail_prev = l_fail;
      s_fail_prev = s_fail;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    sample    = '0;
    sig_table = {SIG1, SIG0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_lax", snap_l(), 40'd0);
    check("reset_strict", snap_s(), 40'd0);
    rst = 1'b0;

    // 1: clean pass, hits 4 cycles apart.
    start_run("t1");
    q_lax.push_back(ev(1, 1, 0, 0, 2'b00, 4));
    q_lax.push_back(ev(1, 2, 1, 0, 2'b00, 8));
    q_str.push_back(ev(1, 1, 0, 0, 2'b00, 4));
    q_str.push_back(ev(1, 2, 1, 0, 2'b00, 8));
    step(SIG0, 4);
    step(SIG1, 4);
    check("t1_pass_lax", snap_l(), mk(0, 1, 2, 1, 0, 0, 8));
    step(SIG1, 3);
    check("t1_sticky_lax", snap_l(), mk(0, 0, 2, 1, 0, 0, 8));
    check("t1_sticky_strict", snap_s(), mk(0, 0, 2, 1, 0, 0, 8));
    end_run("t1");

    // 2: one-cycle gap restarts the stability count; then abort mid-WAIT.
    start_run("t2");
    q_lax.push_back(ev(1, 1, 0, 0, 2'b00, 8));
    q_str.push_back(ev(1, 1, 0, 0, 2'b00, 8));
    step(SIG0, 3);
    step(16'h0000, 1);
    step(SIG0, 4);
    check("t2_hit_lax", snap_l(), mk(1, 1, 1, 0, 0, 0, 8));
    enable = 1'b0;
    step(SIG1, 1);
    check("t2_abort_lax", snap_l(), 40'd0);
    check("t2_abort_strict", snap_s(), 40'd0);

    // 3: timeout after exactly 1000 WAIT cycles.
    start_run("t3");
    q_lax.push_back(ev(0, 0, 0, 1, 2'b01, 1000));
    q_str.push_back(ev(0, 0, 0, 1, 2'b01, 1000));
    step(16'h0000, 999);
    check("t3_before_tmo_lax", snap_l(), mk(1, 0, 0, 0, 0, 0, 999));
    step(16'h0000, 1);
    check("t3_tmo_lax", snap_l(), mk(0, 0, 0, 0, 1, 2'b01, 1000));
    check("t3_tmo_strict", snap_s(), mk(0, 0, 0, 0, 1, 2'b01, 1000));
    end_run("t3");

    // 4: later-stage signature held: strict fails out-of-order, lax times out.
    start_run("t4");
    q_str.push_back(ev(0, 0, 0, 1, 2'b10, 4));
    step(SIG1, 4);
    check("t4_ooo_strict", snap_s(), mk(0, 0, 0, 0, 1, 2'b10, 4));
    check("t4_no_ooo_lax", snap_l(), mk(1, 0, 0, 0, 0, 0, 4));
    q_lax.push_back(ev(0, 0, 0, 1, 2'b01, 1000));
    step(SIG1, 995);
    check("t4_pre_tmo_lax", snap_l(), mk(1, 0, 0, 0, 0, 0, 999));
    check("t4_frozen_strict", snap_s(), mk(0, 0, 0, 0, 1, 2'b10, 4));
    step(SIG1, 1);
    check("t4_tmo_lax", snap_l(), mk(0, 0, 0, 0, 1, 2'b01, 1000));
    end_run("t4");

    // 5: final accept on the edge where cycles == TIMEOUT-1; accept wins.
    start_run("t5");
    q_lax.push_back(ev(1, 1, 0, 0, 2'b00, 996));
    q_lax.push_back(ev(1, 2, 1, 0, 2'b00, 1000));
    q_str.push_back(ev(1, 1, 0, 0, 2'b00, 996));
    q_str.push_back(ev(1, 2, 1, 0, 2'b00, 1000));
    step(16'h0000, 992);
    step(SIG0, 4);
    step(SIG1, 4);
    check("t5_edge_pass_lax", snap_l(), mk(0, 1, 2, 1, 0, 0, 1000));
    check("t5_edge_pass_strict", snap_s(), mk(0, 1, 2, 1, 0, 0, 1000));
    end_run("t5");

    // 6: reset mid-WAIT, then clean restart with enable still high.
    start_run("t6");
    step(SIG0, 2);
    rst = 1'b1;
    step(SIG0, 1);
    check("t6_reset_lax", snap_l(), 40'd0);
    check("t6_reset_strict", snap_s(), 40'd0);
    rst = 1'b0;
    step(SIG0, 1);
    check("t6_restart_lax", snap_l(), mk(1, 0, 0, 0, 0, 0, 0));
    q_lax.push_back(ev(1, 1, 0, 0, 2'b00, 4));
    q_lax.push_back(ev(1, 2, 1, 0, 2'b00, 8));
    q_str.push_back(ev(1, 1, 0, 0, 2'b00, 4));
    q_str.push_back(ev(1, 2, 1, 0, 2'b00, 8));
    step(SIG0, 4);
    step(SIG1, 4);
    check("t6_pass_strict", snap_s(), mk(0, 1, 2, 1, 0, 0, 8));
    end_run("t6");

    step(16'h0000, 2);
    check("lax_queue_drained", 64'(q_lax.size()), 64'd0);
    check("strict_queue_drained", 64'(q_str.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
